// File: rtl/i2cmb_multi_bus_monitor.sv
// i2cmb_multi_bus_monitor
// Per-bus I2C line monitor: input synchronisation, START/STOP detection,
// busy/free tracking with a programmable bus-free time, SCL-low timeout and
// arbitration-loss detection. Every bus has its own private logic.
module i2cmb_multi_bus_monitor #(
  parameter int NUM_BUSES   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_BUSES-1:0] scl_i,
  input  logic [NUM_BUSES-1:0] sda_i,
  input  logic [NUM_BUSES-1:0] sda_drv_low_i,
  input  logic [NUM_BUSES-1:0] master_act_i,
  input  logic [CNT_W-1:0]     free_cycles_i,
  input  logic [CNT_W-1:0]     timeout_cyc_i,
  input  logic [NUM_BUSES-1:0] clr_i,
  output logic [NUM_BUSES-1:0] start_o,
  output logic [NUM_BUSES-1:0] stop_o,
  output logic [NUM_BUSES-1:0] busy_o,
  output logic [NUM_BUSES-1:0] timeout_o,
  output logic [NUM_BUSES-1:0] arb_lost_o,
  output logic                 irq_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_TBUF = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Edge detection is held off until the synchroniser and history flops
  // contain real pad levels; otherwise the reset value (idle high) compared
  // against a low pad would fake a START or STOP right after reset release.
  localparam int              WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic [WARM_W-1:0] warm_q;
  logic              armed;
  logic              irq_q;

  assign armed = (warm_q == WARM_DONE);
  assign irq_o = irq_q;

  // Count cycles since reset release until the line history is trustworthy
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      warm_q <= '0;
    end else if (!armed) begin
      warm_q <= warm_q + WARM_W'(1);
    end
  end

  // Interrupt: any sticky flag or a STOP pulse, delayed by one register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(timeout_o | arb_lost_o | stop_o);
    end
  end

  for (genvar gi = 0; gi < NUM_BUSES; gi++) begin : g_bus
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   start_ev;
    logic                   stop_ev;
    logic                   rise_ev;
    logic                   to_set;
    logic                   arb_set;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [CNT_W-1:0]       free_cnt_q;
    logic [CNT_W-1:0]       free_cnt_d;
    logic [CNT_W-1:0]       scl_cnt_q;
    logic [CNT_W-1:0]       scl_cnt_d;
    logic                   start_q;
    logic                   stop_q;
    logic                   timeout_q;
    logic                   arb_q;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // START/STOP need SCL stable high across the sampled pair, so a cycle in
    // which SCL and SDA both move is treated as an ordinary data transition.
    assign start_ev = armed & scl_s & scl_hist_q & ~sda_s & sda_hist_q;
    assign stop_ev  = armed & scl_s & scl_hist_q & sda_s & ~sda_hist_q;
    assign rise_ev  = armed & scl_s & ~scl_hist_q;
    assign arb_set  = rise_ev & master_act_i[gi] & ~sda_drv_low_i[gi] & ~sda_s;

    // scl_cnt holds the number of earlier consecutive low cycles, so hitting
    // timeout_cyc_i-1 while still low means this is the timeout_cyc_i-th one.
    assign to_set = (timeout_cyc_i != '0) & ~scl_s &
                    (scl_cnt_q == (timeout_cyc_i - CNT_ONE));

    assign scl_cnt_d = scl_s ? '0 :
                       ((scl_cnt_q == CNT_MAX) ? CNT_MAX : scl_cnt_q + CNT_ONE);

    // Bus-state transitions; busy_o drops free_cycles_i+1 cycles after stop_o
    always_comb begin
      state_d    = state_q;
      free_cnt_d = free_cnt_q;
      if (start_ev) begin
        state_d    = ST_BUSY;
        free_cnt_d = '0;
      end else if (stop_ev && (state_q != ST_IDLE)) begin
        state_d    = ST_TBUF;
        free_cnt_d = '0;
      end else if (state_q == ST_TBUF) begin
        if (free_cnt_q == free_cycles_i) begin
          state_d    = ST_IDLE;
          free_cnt_d = '0;
        end else if (scl_s && sda_s) begin
          if (free_cnt_q != CNT_MAX) begin
            free_cnt_d = free_cnt_q + CNT_ONE;
          end
        end else begin
          free_cnt_d = '0;
        end
      end
    end

    // Synchronisers and one history flop per line; reset to idle-high
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        scl_sync_q <= '1;
        sda_sync_q <= '1;
        scl_hist_q <= 1'b1;
        sda_hist_q <= 1'b1;
      end else begin
        scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i[gi]};
        sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i[gi]};
        scl_hist_q <= scl_s;
        sda_hist_q <= sda_s;
      end
    end

    // State, counters, event pulses and sticky flags (set beats clear)
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        state_q    <= ST_IDLE;
        free_cnt_q <= '0;
        scl_cnt_q  <= '0;
        start_q    <= 1'b0;
        stop_q     <= 1'b0;
        timeout_q  <= 1'b0;
        arb_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        free_cnt_q <= free_cnt_d;
        scl_cnt_q  <= scl_cnt_d;
        start_q    <= start_ev;
        stop_q     <= stop_ev;
        timeout_q  <= to_set  | (timeout_q & ~clr_i[gi]);
        arb_q      <= arb_set | (arb_q & ~clr_i[gi]);
      end
    end

    assign start_o[gi]    = start_q;
    assign stop_o[gi]     = stop_q;
    assign busy_o[gi]     = (state_q != ST_IDLE);
    assign timeout_o[gi]  = timeout_q;
    assign arb_lost_o[gi] = arb_q;
  end

endmodule
